pipe_hazard_tracker: RTL and testbench



---
 rtl/pipe_hazard_tracker.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_tracker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_tracker.sv
// -----------------------------------------------------------------------------
// pipe_hazard_tracker
//
// Purpose:
//   Hazard and forwarding tracker for the pipelined MIPS core. It keeps a
//   DEPTH-entry shift register of in-flight destination records, one per
//   stage after decode (stage 1 = EX ... stage DEPTH = WB). Each cycle it
//   looks at the instruction sitting in decode and produces a load-use stall
//   request, one forwarding select per source operand, and a saturating
//   count of stall cycles.
//
// Parameters:
//   DEPTH      number of tracked stages after decode
//   AW         register address width
//   LOAD_STAGE first stage whose load data can be forwarded
//   CNT_W      stall counter width
//   SEL_W      forwarding select width (derived from DEPTH)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   id_valid                  decode holds a real instruction
//   id_rs, id_rt              decode source registers
//   id_use_rs, id_use_rt      source operand is actually read
//   id_rd                     decode destination register
//   id_reg_write, id_mem_read decode control bits
//   flush                     kill the decode instruction this cycle
//   freeze                    hold the whole tracker (multi-cycle memory)
//   stall_req                 load-use hazard: hold PC and IF/ID, bubble EX
//   fwd_rs, fwd_rt            0 = register file, k = result of stage k
//   stage_valid               valid bit per stage, bit k-1 = stage k
//   wb_rd, wb_reg_write       destination and write enable in stage DEPTH
//   stall_count               saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipe_hazard_tracker #(
    parameter int DEPTH      = 3,
    parameter int AW         = 5,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    input  logic             freeze,
    output logic             stall_req,
    output logic [SEL_W-1:0] fwd_rs,
    output logic [SEL_W-1:0] fwd_rt,
    output logic [DEPTH-1:0] stage_valid,
    output logic [AW-1:0]    wb_rd,
    output logic             wb_reg_write,
    output logic [CNT_W-1:0] stall_count
);

    // In-flight destination records, index k-1 holds stage k.
    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0]         r_regWrite;
    logic [DEPTH-1:0]         r_memRead;
    logic [DEPTH-1:0][AW-1:0] r_rd;
    logic [CNT_W-1:0]         r_stallCount;

    // Lookup results: the select of the youngest producer and whether that
    // producer is a load whose data is not yet available.
    logic [SEL_W-1:0] w_rsSel;
    logic [SEL_W-1:0] w_rtSel;
    logic             w_rsEarlyLoad;
    logic             w_rtEarlyLoad;
    logic             w_stall;
    logic             w_accept;

    // Scan from the oldest stage to the youngest so that the last hit, the
    // youngest producer, is the one that sticks. Writes to r0 never match.
    // A load still short of LOAD_STAGE is flagged instead of forwarded.
    function automatic logic [SEL_W:0] youngestMatch(
        input logic [AW-1:0] src,
        input logic          useSrc
    );
        logic [SEL_W-1:0] sel;
        logic             early;
        sel   = '0;
        early = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (useSrc && r_valid[k-1] && r_regWrite[k-1] &&
                (r_rd[k-1] == src) && (src != '0)) begin
                sel   = SEL_W'(k);
                early = r_memRead[k-1] && (k < LOAD_STAGE);
            end
        end
        return {early, sel};
    endfunction

    // Per-operand lookup. An operand whose youngest producer is an early
    // load gets select 0; the stall request keeps that value from being used.
    always_comb begin
        logic [SEL_W:0] rsLook;
        logic [SEL_W:0] rtLook;
        rsLook        = youngestMatch(id_rs, id_use_rs);
        rtLook        = youngestMatch(id_rt, id_use_rt);
        w_rsEarlyLoad = rsLook[SEL_W];
        w_rtEarlyLoad = rtLook[SEL_W];
        w_rsSel       = w_rsEarlyLoad ? '0 : rsLook[SEL_W-1:0];
        w_rtSel       = w_rtEarlyLoad ? '0 : rtLook[SEL_W-1:0];
    end

    // A flushed decode slot never stalls; the bubble it becomes is harmless.
    // Only an unstalled, unflushed real instruction enters stage 1.
    assign w_stall  = id_valid && !flush && (w_rsEarlyLoad || w_rtEarlyLoad);
    assign w_accept = id_valid && !flush && !w_stall;

    // Shift the records one stage per cycle unless frozen. Stage 1 takes the
    // decode record when it is accepted, otherwise a fully zeroed bubble so
    // stale rd values never linger in the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= '0;
            r_regWrite <= '0;
            r_memRead  <= '0;
            r_rd       <= '0;
        end else if (!freeze) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_valid[k]    <= r_valid[k-1];
                r_regWrite[k] <= r_regWrite[k-1];
                r_memRead[k]  <= r_memRead[k-1];
                r_rd[k]       <= r_rd[k-1];
            end
            r_valid[0]    <= w_accept;
            r_regWrite[0] <= w_accept && id_reg_write;
            r_memRead[0]  <= w_accept && id_mem_read;
            r_rd[0]       <= w_accept ? id_rd : '0;
        end
    end

    // Count every stall cycle that actually holds the pipeline; a frozen
    // cycle is not a stall cycle. The count pins at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCount <= '0;
        end else if (w_stall && !freeze && (r_stallCount != '1)) begin
            r_stallCount <= r_stallCount + 1'b1;
        end
    end

    assign stall_req    = w_stall;
    assign fwd_rs       = w_rsSel;
    assign fwd_rt       = w_rtSel;
    assign stage_valid  = r_valid;
    assign wb_rd        = r_rd[DEPTH-1];
    assign wb_reg_write = r_valid[DEPTH-1] && r_regWrite[DEPTH-1];
    assign stall_count  = r_stallCount;

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_tracker
//
// Directed scenarios (ALU chain, load-use, r0, priority, flush, freeze,
// asynchronous reset) followed by a long randomized run, all compared against
// a stage-array reference model. The counter is built 4 bits wide so the
// random run drives it into saturation.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_tracker;

    localparam int DEPTH      = 3;
    localparam int AW         = 5;
    localparam int LOAD_STAGE = 2;
    localparam int CNT_W      = 4;
    localparam int SEL_W      = 2;
    localparam int CNT_MAX    = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [AW-1:0]    id_rs;
    logic [AW-1:0]    id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [AW-1:0]    id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             freeze;
    logic             stall_req;
    logic [SEL_W-1:0] fwd_rs;
    logic [SEL_W-1:0] fwd_rt;
    logic [DEPTH-1:0] stage_valid;
    logic [AW-1:0]    wb_rd;
    logic             wb_reg_write;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          v;
        logic          rw;
        logic          mr;
        logic [AW-1:0] rd;
    } rec_t;

    rec_t pipe [1:DEPTH];
    int   modelCount;

    pipe_hazard_tracker #(
        .DEPTH(DEPTH), .AW(AW), .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .freeze(freeze), .stall_req(stall_req), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .stage_valid(stage_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .stall_count(stall_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Count one comparison and report it when the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive every decode-side input at once.
    task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic ua, input logic ub, input logic [AW-1:0] d,
                                 input logic w, input logic m, input logic fl, input logic fz);
        id_valid     = v;
        id_rs        = a;
        id_rt        = b;
        id_use_rs    = ua;
        id_use_rt    = ub;
        id_rd        = d;
        id_reg_write = w;
        id_mem_read  = m;
        flush        = fl;
        freeze       = fz;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic modelReset();
        for (int k = 1; k <= DEPTH; k++) pipe[k] = '0;
        modelCount = 0;
    endtask

    // Reference lookup: walk stages from youngest (1) to oldest and stop at
    // the first producer of src. early says that producer is a load whose
    // data is not ready yet.
    function automatic void lookup(input logic [AW-1:0] src, input logic useSrc,
                                   output int sel, output bit early);
        sel   = 0;
        early = 1'b0;
        if (!useSrc || src == 0) return;
        for (int k = 1; k <= DEPTH; k++) begin
            if (pipe[k].v && pipe[k].rw && pipe[k].rd == src) begin
                sel   = k;
                early = pipe[k].mr && (k < LOAD_STAGE);
                return;
            end
        end
    endfunction

    function automatic bit modelStall();
        int sRs, sRt;
        bit eRs, eRt;
        lookup(id_rs, id_use_rs, sRs, eRs);
        lookup(id_rt, id_use_rt, sRt, eRt);
        return id_valid && !flush && (eRs || eRt);
    endfunction

    task automatic checkModel();
        int sRs, sRt;
        bit eRs, eRt;
        bit expStall;
        logic [DEPTH-1:0] expValid;
        lookup(id_rs, id_use_rs, sRs, eRs);
        lookup(id_rt, id_use_rt, sRt, eRt);
        expStall = modelStall();
        for (int k = 1; k <= DEPTH; k++) expValid[k-1] = pipe[k].v;
        checkOutput("m_stall_req", 32'(stall_req), 32'(expStall));
        if (!expStall && !eRs) checkOutput("m_fwd_rs", 32'(fwd_rs), 32'(sRs));
        if (!expStall && !eRt) checkOutput("m_fwd_rt", 32'(fwd_rt), 32'(sRt));
        checkOutput("m_stage_valid", 32'(stage_valid), 32'(expValid));
        checkOutput("m_wb_rd", 32'(wb_rd), 32'(pipe[DEPTH].rd));
        checkOutput("m_wb_reg_write", 32'(wb_reg_write), 32'(pipe[DEPTH].v && pipe[DEPTH].rw));
        checkOutput("m_stall_count", 32'(stall_count), 32'(modelCount));
    endtask

    // Advance the model by one clock edge using the inputs held this cycle.
    task automatic updateModel();
        bit st;
        st = modelStall();
        if (!freeze) begin
            if (st && modelCount < CNT_MAX) modelCount++;
            for (int k = DEPTH; k >= 2; k--) pipe[k] = pipe[k-1];
            if (id_valid && !flush && !st) begin
                pipe[1].v  = 1'b1;
                pipe[1].rw = id_reg_write;
                pipe[1].mr = id_mem_read;
                pipe[1].rd = id_rd;
            end else begin
                pipe[1] = '0;
            end
        end
    endtask

    // Inputs are set just after a rising edge; check at the falling edge,
    // then step the model on the next rising edge.
    task automatic cycleStep();
        @(negedge clk);
        checkModel();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic idleCycles(input int n);
        applyIdle();
        for (int i = 0; i < n; i++) cycleStep();
    endtask

    initial begin
        applyIdle();
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(2);

        // ALU chain: add r3; sub uses r3 as rs; and uses r3 as rt.
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);
        #2 checkOutput("alu_add_stall", 32'(stall_req), 0);
        cycleStep();
        applyStimulus(1, 5'd3, 5'd6, 1, 1, 5'd4, 1, 0, 0, 0);
        #2 checkOutput("alu_sub_fwd_rs", 32'(fwd_rs), 1);
        checkOutput("alu_sub_stall", 32'(stall_req), 0);
        cycleStep();
        applyStimulus(1, 5'd8, 5'd3, 1, 1, 5'd9, 1, 0, 0, 0);
        #2 checkOutput("alu_and_fwd_rt", 32'(fwd_rt), 2);
        checkOutput("alu_and_fwd_rs", 32'(fwd_rs), 0);
        checkOutput("alu_and_stall", 32'(stall_req), 0);
        cycleStep();

        // Load-use: lw r5 then add rs=5 -> one stall cycle, then forward from stage 2.
        idleCycles(3);
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);
        cycleStep();
        applyStimulus(1, 5'd5, 5'd2, 1, 1, 5'd10, 1, 0, 0, 0);
        #2 checkOutput("lu_stall_first", 32'(stall_req), 1);
        cycleStep();
        #2 checkOutput("lu_stall_second", 32'(stall_req), 0);
        checkOutput("lu_fwd_rs", 32'(fwd_rs), 2);
        checkOutput("lu_bubble", 32'(stage_valid[0]), 0);
        checkOutput("lu_count", 32'(stall_count), 1);
        cycleStep();

        // A producer writing r0 never forwards.
        idleCycles(3);
        applyStimulus(1, 5'd1, 5'd1, 1, 1, 5'd0, 1, 0, 0, 0);
        cycleStep();
        applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd11, 1, 0, 0, 0);
        #2 checkOutput("r0_fwd_rs", 32'(fwd_rs), 0);
        checkOutput("r0_fwd_rt", 32'(fwd_rt), 0);
        cycleStep();

        // r7 produced in stages 3 and 1: the younger one wins, rs==rt agree.
        idleCycles(3);
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0, 0);
        cycleStep();
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd12, 1, 0, 0, 0);
        cycleStep();
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0, 0);
        cycleStep();
        applyStimulus(1, 5'd7, 5'd7, 1, 1, 5'd13, 1, 0, 0, 0);
        #2 checkOutput("prio_fwd_rs", 32'(fwd_rs), 1);
        checkOutput("prio_fwd_rt", 32'(fwd_rt), 1);
        cycleStep();

        // Flush during a hazard: no stall, a bubble enters stage 1.
        idleCycles(3);
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd6, 1, 1, 0, 0);
        cycleStep();
        applyStimulus(1, 5'd6, 5'd2, 1, 1, 5'd14, 1, 0, 1, 0);
        #2 checkOutput("flush_stall", 32'(stall_req), 0);
        cycleStep();
        applyIdle();
        #2 checkOutput("flush_bubble", 32'(stage_valid), 32'b010);
        cycleStep();

        // Freeze during a hazard: stall stays up, nothing moves or counts.
        idleCycles(3);
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd6, 1, 1, 0, 0);
        cycleStep();
        applyStimulus(1, 5'd6, 5'd2, 1, 1, 5'd14, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #2 checkOutput("frz_stall", 32'(stall_req), 1);
            checkOutput("frz_stage_valid", 32'(stage_valid), 32'b001);
            checkOutput("frz_count", 32'(stall_count), 1);
            cycleStep();
        end
        freeze = 1'b0;
        #2 checkOutput("frz_release_stall", 32'(stall_req), 1);
        cycleStep();
        #2 checkOutput("frz_after_stall", 32'(stall_req), 0);
        checkOutput("frz_after_fwd", 32'(fwd_rs), 2);
        checkOutput("frz_after_count", 32'(stall_count), 2);
        cycleStep();

        // Asynchronous reset in the middle of a cycle clears at once.
        applyStimulus(1, 5'd6, 5'd6, 1, 1, 5'd5, 1, 0, 0, 0);
        #1 rst = 1'b1;
        #1 checkOutput("arst_stall", 32'(stall_req), 0);
        checkOutput("arst_fwd_rs", 32'(fwd_rs), 0);
        checkOutput("arst_fwd_rt", 32'(fwd_rt), 0);
        checkOutput("arst_stage_valid", 32'(stage_valid), 0);
        checkOutput("arst_wb_rd", 32'(wb_rd), 0);
        checkOutput("arst_wb_reg_write", 32'(wb_reg_write), 0);
        checkOutput("arst_count", 32'(stall_count), 0);
        modelReset();
        @(posedge clk);
        #1 rst = 1'b0;
        idleCycles(5);
        #2 checkOutput("idle_stage_valid", 32'(stage_valid), 0);

        // Randomized traffic over a small register set so matches are common.
        for (int i = 0; i < 3000; i++) begin
            logic rw;
            rw = ($urandom_range(0, 99) < 75);
            applyStimulus($urandom_range(0, 99) < 85,
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 80,
                          AW'($urandom_range(0, 7)), rw,
                          rw && ($urandom_range(0, 99) < 35),
                          $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10);
            cycleStep();
        end
        checkOutput("sat_model_reached", 32'(stall_count), 32'(modelCount));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
